// File: rtl/qoi_framer_pkg.sv
// Shared types and constants for the QOI stream framer (package qoi_types).
package qoi_types;

  typedef logic [7:0] byte_t;
  typedef logic [2:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_BODY    = 3'd2,
`ifdef QOI_FRAMER_TRAILER_EN
    ST_TRAILER = 3'd3,
`endif
    ST_DRAIN   = 3'd4
  } framer_state_t;

  localparam logic [31:0] QOI_MAGIC   = 32'h716F6966;
  localparam int          QOI_HDR_LEN = 14;
  localparam int          QOI_END_LEN = 8;

  localparam addr_t ADDR_DATA      = 3'd0;
  localparam addr_t ADDR_STATUS    = 3'd1;
  localparam addr_t ADDR_WIDTH_LO  = 3'd2;
  localparam addr_t ADDR_WIDTH_HI  = 3'd3;
  localparam addr_t ADDR_HEIGHT_LO = 3'd4;
  localparam addr_t ADDR_HEIGHT_HI = 3'd5;
  localparam addr_t ADDR_CTRL      = 3'd6;

  // Header byte idx (0 = first on the wire); dimensions are 32-bit big-endian with zero upper half.
  function automatic byte_t hdr_byte(input logic [3:0] idx, input logic [15:0] w,
                                     input logic [15:0] h, input logic ch4, input logic cspace);
    logic [8*QOI_HDR_LEN-1:0] hdr;
    hdr = {QOI_MAGIC, 16'h0000, w, 16'h0000, h, (ch4 ? 8'd4 : 8'd3), 7'd0, cspace};
    return hdr[8*(QOI_HDR_LEN-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/qoi_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; head reads 0x00 when empty.
module qoi_byte_fifo
  import qoi_types::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output byte_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;
  byte_t       mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/qoi_framer.sv
// Frames encoded QOI chunk bytes with the 14-byte header (plus end marker when
// QOI_FRAMER_TRAILER_EN is defined) into a byte FIFO drained over a 6502-style bus.
//
// state   | meaning
// IDLE    | waiting for start; done/underflow hold
// HEADER  | pushing the 14 header bytes
// BODY    | forwarding encoder bytes until in_last
// TRAILER | pushing 00x7 01 end marker (QOI_FRAMER_TRAILER_EN only)
// DRAIN   | waiting for the host to empty the FIFO
module qoi_framer
  import qoi_types::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  byte_t in_data,
  input  logic  in_valid,
  output logic  in_ready,
  input  logic  in_last,
  input  logic  cs,
  input  logic  we,
  input  addr_t addr,
  input  byte_t data_i,
  output byte_t data_o
);

  framer_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   width_q, width_d;
  logic [15:0]   height_q, height_d;
  logic          ch4_q, ch4_d;
  logic          cspace_q, cspace_d;
  logic          done_q, done_d;
  logic          underflow_q, underflow_d;

  logic  fifo_push, fifo_pop, fifo_full, fifo_empty;
  byte_t fifo_wdata, fifo_head, status;
  logic  busy, rd_data, wr_cfg;

  qoi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy     = (state_q != ST_IDLE);
  assign rd_data  = cs && !we && (addr == ADDR_DATA);
  assign wr_cfg   = cs && we && !busy;
  assign fifo_pop = rd_data && !fifo_empty;
  assign status   = {busy, done_q, underflow_q, fifo_full, fifo_empty, state_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    width_d     = width_q;
    height_d    = height_q;
    ch4_d       = ch4_q;
    cspace_d    = cspace_q;
    done_d      = done_q;
    underflow_d = underflow_q;
    fifo_push   = 1'b0;
    fifo_wdata  = 8'h00;
    in_ready    = 1'b0;

    if (rd_data && fifo_empty) underflow_d = 1'b1;

    if (wr_cfg) begin
      case (addr)
        ADDR_WIDTH_LO:  width_d[7:0]   = data_i;
        ADDR_WIDTH_HI:  width_d[15:8]  = data_i;
        ADDR_HEIGHT_LO: height_d[7:0]  = data_i;
        ADDR_HEIGHT_HI: height_d[15:8] = data_i;
        ADDR_CTRL: begin
          ch4_d    = data_i[1];
          cspace_d = data_i[2];
          if (data_i[0]) begin
            state_d     = ST_HEADER;
            cnt_d       = 4'(QOI_HDR_LEN - 1);
            done_d      = 1'b0;
            underflow_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // cnt_q counts down remaining bytes of the current fixed sequence.
    case (state_q)
      ST_IDLE: ;
      ST_HEADER: begin
        fifo_push  = !fifo_full;
        fifo_wdata = hdr_byte(4'(QOI_HDR_LEN - 1) - cnt_q, width_q, height_q, ch4_q, cspace_q);
        if (!fifo_full) begin
          if (cnt_q == 4'd0) state_d = ST_BODY;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_BODY: begin
        in_ready   = !fifo_full;
        fifo_push  = in_valid && !fifo_full;
        fifo_wdata = in_data;
        if (fifo_push && in_last) begin
`ifdef QOI_FRAMER_TRAILER_EN
          state_d = ST_TRAILER;
          cnt_d   = 4'(QOI_END_LEN - 1);
`else
          state_d = ST_DRAIN;
`endif
        end
      end
`ifdef QOI_FRAMER_TRAILER_EN
      ST_TRAILER: begin
        fifo_push  = !fifo_full;
        fifo_wdata = (cnt_q == 4'd0) ? 8'h01 : 8'h00;
        if (!fifo_full) begin
          if (cnt_q == 4'd0) state_d = ST_DRAIN;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
`endif
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_o = 8'h00;
    case (addr)
      ADDR_DATA:      data_o = fifo_head;
      ADDR_STATUS:    data_o = status;
      ADDR_WIDTH_LO:  data_o = width_q[7:0];
      ADDR_WIDTH_HI:  data_o = width_q[15:8];
      ADDR_HEIGHT_LO: data_o = height_q[7:0];
      ADDR_HEIGHT_HI: data_o = height_q[15:8];
      default:        data_o = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      width_q     <= 16'h0000;
      height_q    <= 16'h0000;
      ch4_q       <= 1'b0;
      cspace_q    <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      height_q    <= height_d;
      ch4_q       <= ch4_d;
      cspace_q    <= cspace_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
